// File: rtl/mac_layer_sequencer.sv
// Sequences one dense CNN layer on a signed MAC datapath: fetch feature/weight pairs,
// accumulate per neuron, stream each result on AXI-Stream, raise a sticky done interrupt.
module mac_layer_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned WADDR_W = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [OUT_W-1:0]   cfg_nout,
  input  logic [WADDR_W-1:0] cfg_wbase,
  output logic               busy,
  output logic               done_irq,
  input  logic               irq_ack,
  output logic               feat_rd_en,
  output logic [LEN_W-1:0]   feat_addr,
  input  logic [DATA_W-1:0]  feat_data,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]  w_data,
  output logic [ACC_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [OUT_W-1:0]   out_idx
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    len_q;
  logic [OUT_W-1:0]    nout_q;
  logic [LEN_W-1:0]    k;
  logic [WADDR_W-1:0]  wptr;
  logic [ACC_W-1:0]    acc;
  logic                rd_vld_d1;

  // Full-width signed product of the operands returned by the RAMs this cycle
  logic signed [PROD_W-1:0] feat_sx;
  logic signed [PROD_W-1:0] w_sx;
  logic signed [PROD_W-1:0] prod;

  assign feat_sx = PROD_W'($signed(feat_data));
  assign w_sx    = PROD_W'($signed(w_data));
  assign prod    = feat_sx * w_sx;

  // The accumulator register doubles as the held stream payload while in OUT
  assign m_axis_tdata = acc;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      len_q         <= '0;
      nout_q        <= '0;
      k             <= '0;
      wptr          <= '0;
      acc           <= '0;
      rd_vld_d1     <= 1'b0;
      busy          <= 1'b0;
      done_irq      <= 1'b0;
      feat_rd_en    <= 1'b0;
      feat_addr     <= '0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      out_idx       <= '0;
    end else begin
      rd_vld_d1 <= feat_rd_en;
      if (rd_vld_d1) begin
        acc <= acc + ACC_W'(prod);
      end
      // Acknowledge only clears; a set in DONE below takes priority
      if (irq_ack) begin
        done_irq <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            len_q   <= cfg_len;
            nout_q  <= cfg_nout;
            wptr    <= cfg_wbase;
            k       <= '0;
            out_idx <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            if ((cfg_len == '0) || (cfg_nout == '0)) begin
              state <= S_DONE;
            end else begin
              state      <= S_RUN;
              feat_rd_en <= 1'b1;
              w_rd_en    <= 1'b1;
              feat_addr  <= '0;
              w_addr     <= cfg_wbase;
            end
          end
        end

        S_RUN: begin
          if (k == len_q - LEN_W'(1)) begin
            state      <= S_DRAIN;
            feat_rd_en <= 1'b0;
            w_rd_en    <= 1'b0;
          end else begin
            k         <= k + LEN_W'(1);
            feat_addr <= k + LEN_W'(1);
            w_addr    <= wptr + WADDR_W'(k + LEN_W'(1));
          end
        end

        S_DRAIN: begin
          state         <= S_OUT;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= (out_idx == nout_q - OUT_W'(1));
        end

        S_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            acc           <= '0;
            k             <= '0;
            wptr          <= wptr + WADDR_W'(len_q);
            if (m_axis_tlast) begin
              state <= S_DONE;
            end else begin
              state      <= S_RUN;
              out_idx    <= out_idx + OUT_W'(1);
              feat_rd_en <= 1'b1;
              w_rd_en    <= 1'b1;
              feat_addr  <= '0;
              w_addr     <= wptr + WADDR_W'(len_q);
            end
          end
        end

        S_DONE: begin
          done_irq <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
